// File: rtl/fft_run_sequencer.sv
// fft_run_sequencer: bus master that loads every butterfly node, arms the FFT count-down, then reads back and streams out the results.
//   clk_i, rst_ni         : rising-edge clock, asynchronous active-low reset
//   start_i, cfg_stages_i : begin a pass (IDLE only) with the Enable cycle count
//   busy_o, done_o        : pass in progress / one-cycle end-of-pass pulse
//   in_valid_i, in_data_i, in_ready_o    : operand pair stream {right, left}
//   out_valid_o, out_data_o, out_ready_i : result pair stream {right, left}
//   bus_rd_o, bus_wr_o, bus_addr_o, bus_wdata_o, bus_rdata_i : node/control bus
module fft_run_sequencer #(
    parameter int SIZE      = 4,
    parameter int NODES     = 4,
    parameter int IDWIDTH   = 8,
    parameter int ADDRW     = 8,
    parameter int DATAW     = 16,
    parameter int NODE_BASE = 0,
    parameter int CTRL_ID   = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [7:0]            cfg_stages_i,
    output logic                  busy_o,
    output logic                  done_o,
    input  logic                  in_valid_i,
    input  logic [2*SIZE+1:0]     in_data_i,
    output logic                  in_ready_o,
    output logic                  out_valid_o,
    output logic [2*SIZE+1:0]     out_data_o,
    input  logic                  out_ready_i,
    output logic                  bus_rd_o,
    output logic                  bus_wr_o,
    output logic [ADDRW-1:0]      bus_addr_o,
    output logic [DATAW-1:0]      bus_wdata_o,
    input  logic [DATAW-1:0]      bus_rdata_i
);
    localparam int PW = SIZE + 1;
    localparam int IW = NODES > 1 ? $clog2(NODES) : 1;

    typedef enum logic [3:0] {IDLE, LWAIT, WL, WR, WS, ARM, RUN, RL, RR, RS, EMIT, FIN} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [7:0]        stages_q, stages_d, cnt_q, cnt_d;
    logic [2*PW-1:0]   pair_q, pair_d, out_data_d;
    logic [SIZE-1:0]   rl_q, rl_d, rr_q, rr_d;
    logic              last;
    logic [ADDRW-1:0]  addr_d;
    logic [DATAW-1:0]  wdata_d;
    logic              rd_d, wr_d;
    logic              unused_rdata;

    assign unused_rdata = ^bus_rdata_i[DATAW-1:SIZE];
    assign last = idx_q == IW'(NODES - 1);

    // Node ids are decoded on the low IDWIDTH address bits only.
    function automatic logic [ADDRW-1:0] node_id(input logic [IW-1:0] n, input int k);
        return ADDRW'(IDWIDTH'(NODE_BASE + 4 * int'(n) + k));
    endfunction

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        stages_d = stages_q;
        cnt_d    = cnt_q;
        pair_d   = pair_q;
        rl_d     = rl_q;
        rr_d     = rr_q;
        case (state_q)
            IDLE:  if (start_i) begin
                       stages_d = cfg_stages_i;
                       idx_d    = '0;
                       state_d  = LWAIT;
                   end
            LWAIT: if (in_valid_i && in_ready_o) begin
                       pair_d  = in_data_i;
                       state_d = WL;
                   end
            WL:    state_d = WR;
            WR:    state_d = WS;
            WS:    begin
                       idx_d   = last ? '0 : idx_q + 1'b1;
                       state_d = last ? ARM : LWAIT;
                   end
            ARM:   begin
                       cnt_d   = stages_q;
                       state_d = stages_q == 8'd0 ? RL : RUN;
                   end
            // Mirrors the control block's count-down: exactly cfg_stages RUN cycles.
            RUN:   begin
                       cnt_d   = cnt_q == 8'd1 ? 8'd0 : cnt_q - 8'd1;
                       state_d = cnt_q == 8'd1 ? RL : RUN;
                   end
            RL:    begin
                       rl_d    = bus_rdata_i[SIZE-1:0];
                       state_d = RR;
                   end
            RR:    begin
                       rr_d    = bus_rdata_i[SIZE-1:0];
                       state_d = RS;
                   end
            RS:    state_d = EMIT;
            EMIT:  if (out_ready_i) begin
                       idx_d   = last ? idx_q : idx_q + 1'b1;
                       state_d = last ? FIN : RL;
                   end
            FIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every output is a flop.
    always_comb begin
        wr_d    = state_d inside {WL, WR, WS, ARM};
        rd_d    = state_d inside {RL, RR, RS};
        addr_d  = state_d == ARM              ? ADDRW'(CTRL_ID)   :
                  state_d inside {WL, RL}     ? node_id(idx_d, 1) :
                  state_d inside {WR, RR}     ? node_id(idx_d, 2) :
                  state_d inside {WS, RS}     ? node_id(idx_d, 3) : '0;
        wdata_d = state_d == WL  ? DATAW'(pair_d[SIZE-1:0])              :
                  state_d == WR  ? DATAW'(pair_d[PW+SIZE-1:PW])          :
                  state_d == WS  ? DATAW'({pair_d[2*PW-1], pair_d[SIZE]}) :
                  state_d == ARM ? DATAW'(stages_d)                      : '0;
        out_data_d = state_q == RS   ? {bus_rdata_i[1], rr_q, bus_rdata_i[0], rl_q} :
                     state_d == EMIT ? out_data_o : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            stages_q    <= '0;
            cnt_q       <= '0;
            pair_q      <= '0;
            rl_q        <= '0;
            rr_q        <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            in_ready_o  <= 1'b0;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            bus_rd_o    <= 1'b0;
            bus_wr_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            stages_q    <= stages_d;
            cnt_q       <= cnt_d;
            pair_q      <= pair_d;
            rl_q        <= rl_d;
            rr_q        <= rr_d;
            busy_o      <= state_d != IDLE && state_d != FIN;
            done_o      <= state_d == FIN;
            in_ready_o  <= state_d == LWAIT;
            out_valid_o <= state_d == EMIT;
            out_data_o  <= out_data_d;
            bus_rd_o    <= rd_d;
            bus_wr_o    <= wr_d;
            bus_addr_o  <= addr_d;
            bus_wdata_o <= wdata_d;
        end
    end
endmodule

// File: tb/tb_fft_run_sequencer.sv
// tb_fft_run_sequencer: scoreboard bench for fft_run_sequencer with a memory-backed node bus model.
module tb_fft_run_sequencer;
    localparam int CTRL = 255;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        start = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [7:0]  cfg = 8'd0;
    logic [9:0]  in_data = '0;
    logic        busy, done, in_ready, out_valid, bus_rd, bus_wr;
    logic [9:0]  out_data;
    logic [7:0]  bus_addr;
    logic [15:0] bus_wdata, bus_rdata;

    logic [15:0] mem [256];
    logic        ovr_en = 1'b0;
    logic [1:0]  ovr = 2'b00;

    logic [7:0]  wa_q [$];
    logic [15:0] wd_q [$];
    logic [7:0]  ra_q [$];
    logic [9:0]  od_q [$];
    logic [4:0]  pl [4];
    logic [4:0]  pr [4];

    int total = 0, bad = 0, cyc = 0;
    int last_wr_cyc = 0, arm_cyc = 0, first_rd_cyc = 0, done_cnt = 0;
    bit rd_seen = 0;
    logic [7:0]  m_a;
    logic [15:0] m_d;
    logic [9:0]  m_o;

    fft_run_sequencer dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .cfg_stages_i(cfg),
        .busy_o(busy), .done_o(done),
        .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
        .out_valid_o(out_valid), .out_data_o(out_data), .out_ready_i(out_ready),
        .bus_rd_o(bus_rd), .bus_wr_o(bus_wr), .bus_addr_o(bus_addr),
        .bus_wdata_o(bus_wdata), .bus_rdata_i(bus_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (bus_wr) mem[bus_addr] <= bus_wdata;
    assign bus_rdata = !bus_rd ? 16'h0 : (ovr_en && bus_addr[1:0] == 2'd3) ? {14'h0, ovr} : mem[bus_addr];

    always @(negedge clk) if (rst_n) begin
        total++;
        if ((bus_rd && bus_wr) || (!bus_rd && !bus_wr && (bus_addr != 0 || bus_wdata != 0))) begin
            bad++;
            $display("FAIL bus_idle rd=%b wr=%b addr=%0d wdata=%h required exclusive strobes and zero idle bus", bus_rd, bus_wr, bus_addr, bus_wdata);
        end
        if (bus_wr) begin
            total++;
            last_wr_cyc = cyc;
            if (bus_addr == CTRL) arm_cyc = cyc;
            if (wa_q.size() == 0) begin
                bad++;
                $display("FAIL bus_write unexpected addr=%0d wdata=%h", bus_addr, bus_wdata);
            end else begin
                m_a = wa_q.pop_front();
                m_d = wd_q.pop_front();
                if (bus_addr !== m_a || bus_wdata !== m_d) begin
                    bad++;
                    $display("FAIL bus_write got addr=%0d wdata=%h required addr=%0d wdata=%h", bus_addr, bus_wdata, m_a, m_d);
                end
            end
        end
        if (bus_rd) begin
            total++;
            if (!rd_seen) begin first_rd_cyc = cyc; rd_seen = 1; end
            if (ra_q.size() == 0) begin
                bad++;
                $display("FAIL bus_read unexpected addr=%0d", bus_addr);
            end else begin
                m_a = ra_q.pop_front();
                if (bus_addr !== m_a) begin
                    bad++;
                    $display("FAIL bus_read got addr=%0d required %0d", bus_addr, m_a);
                end
            end
        end
        if (out_valid && out_ready) begin
            total++;
            if (od_q.size() == 0) begin
                bad++;
                $display("FAIL out_data unexpected %b", out_data);
            end else begin
                m_o = od_q.pop_front();
                if (out_data !== m_o) begin
                    bad++;
                    $display("FAIL out_data got %b required %b", out_data, m_o);
                end
            end
        end
        if (done) done_cnt++;
    end

    task automatic push_exp(input logic [7:0] c);
        for (int k = 0; k < 4; k++) begin
            wa_q.push_back(8'(4*k+1)); wd_q.push_back({12'h0, pl[k][3:0]});
            wa_q.push_back(8'(4*k+2)); wd_q.push_back({12'h0, pr[k][3:0]});
            wa_q.push_back(8'(4*k+3)); wd_q.push_back({14'h0, pr[k][4], pl[k][4]});
            ra_q.push_back(8'(4*k+1)); ra_q.push_back(8'(4*k+2)); ra_q.push_back(8'(4*k+3));
            od_q.push_back({ovr_en ? ovr[1] : pr[k][4], pr[k][3:0], ovr_en ? ovr[0] : pl[k][4], pl[k][3:0]});
        end
        wa_q.push_back(8'(CTRL)); wd_q.push_back({8'h0, c});
        rd_seen = 0;
    endtask

    task automatic do_start(input logic [7:0] c);
        @(posedge clk); #1;
        start = 1; cfg = c;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic load_pairs(input bit tog, input bit dup);
        bit hs;
        int n;
        logic [7:0] keep;
        for (int k = 0; k < 4; k++) begin
            in_data = {pr[k], pl[k]};
            in_valid = 1; hs = 0; n = 0;
            while (!hs && n < 60) begin
                @(negedge clk);
                hs = in_valid && in_ready;
                @(posedge clk); #1;
                n++;
                if (!hs && tog) in_valid = ~in_valid;
            end
            in_valid = 0;
            total++;
            if (!hs) begin bad++; $display("FAIL load_handshake node=%0d got no handshake required one within 60 cycles", k); end
            if (tog) begin @(posedge clk); #1; end
            if (k == 0 && dup) begin
                keep = cfg;
                start = 1; cfg = 8'd9;
                @(posedge clk); #1;
                start = 0; cfg = keep;
            end
        end
    endtask

    task automatic finish_pass(input logic [7:0] c, input bit stall);
        bit seen = 0;
        int dc = 0;
        logic [9:0] cap;
        if (stall) begin
            for (int n = 0; n < 200 && !seen; n++) begin @(negedge clk); seen = out_valid; end
            total++;
            if (!seen) begin bad++; $display("FAIL stall_wait got out_valid=0 required 1 within 200 cycles"); end
            cap = out_data;
            for (int s = 0; s < 5; s++) begin
                @(negedge clk);
                total++;
                if (out_valid !== 1'b1 || out_data !== cap || bus_rd !== 1'b0) begin
                    bad++;
                    $display("FAIL stall_hold got valid=%b data=%b rd=%b required valid=1 data=%b rd=0", out_valid, out_data, bus_rd, cap);
                end
            end
            @(posedge clk); #1;
            out_ready = 1;
            seen = 0;
        end
        for (int n = 0; n < 400 && !seen; n++) begin @(negedge clk); seen = done; dc = cyc; end
        total++;
        if (!seen) begin bad++; $display("FAIL done_wait got no done required done within 400 cycles"); end
        total++;
        if (dc - last_wr_cyc < 12) begin bad++; $display("FAIL done_gap got %0d required >=12", dc - last_wr_cyc); end
        total++;
        if (first_rd_cyc - arm_cyc != int'(c) + 1) begin
            bad++;
            $display("FAIL run_cycles got %0d required %0d", first_rd_cyc - arm_cyc - 1, c);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL done_pulse got busy=%b done=%b required 0 0", busy, done); end
        total++;
        if (wa_q.size() || ra_q.size() || od_q.size()) begin
            bad++;
            $display("FAIL scoreboard_left got w=%0d r=%0d o=%0d required all 0", wa_q.size(), ra_q.size(), od_q.size());
        end
    endtask

    task automatic check_zero(input string tag);
        total++;
        if ({busy, done, in_ready, out_valid, out_data, bus_rd, bus_wr, bus_addr, bus_wdata} !== '0) begin
            bad++;
            $display("FAIL %s got busy=%b done=%b rdy=%b ov=%b od=%b rd=%b wr=%b a=%0d d=%h required all 0",
                     tag, busy, done, in_ready, out_valid, out_data, bus_rd, bus_wr, bus_addr, bus_wdata);
        end
    endtask

    task automatic test_reset;
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1 check_zero("reset_state");
        @(negedge clk) rst_n = 1;
        repeat (3) @(negedge clk);
        check_zero("idle_after_reset");
    endtask

    task automatic test_basic;
        pl = '{5'd1, 5'd3, 5'd5, 5'd7};
        pr = '{5'd2, 5'd4, 5'd6, 5'd8};
        push_exp(8'd0); do_start(8'd0); load_pairs(0, 0); finish_pass(8'd0, 0);
    endtask

    task automatic test_run_stages;
        pl = '{5'h1f, 5'h00, 5'h1a, 5'h03};
        pr = '{5'h10, 5'h0f, 5'h05, 5'h19};
        push_exp(8'd3); do_start(8'd3); load_pairs(0, 0); finish_pass(8'd3, 0);
    endtask

    task automatic test_sign;
        pl = '{5'b10000, 5'd2, 5'd9, 5'd4};
        pr = '{5'd5, 5'd11, 5'd6, 5'd13};
        ovr_en = 1; ovr = 2'b10;
        push_exp(8'd0); do_start(8'd0); load_pairs(0, 0); finish_pass(8'd0, 0);
        ovr_en = 0;
    endtask

    task automatic test_stall;
        pl = '{5'd6, 5'd14, 5'd0, 5'd15};
        pr = '{5'd9, 5'd1, 5'd12, 5'd7};
        out_ready = 0;
        push_exp(8'd1); do_start(8'd1); load_pairs(0, 0); finish_pass(8'd1, 1);
    endtask

    task automatic test_back_to_back;
        int d0;
        pl = '{5'd8, 5'd17, 5'd2, 5'd25};
        pr = '{5'd3, 5'd10, 5'd30, 5'd4};
        d0 = done_cnt;
        push_exp(8'd2); do_start(8'd2); load_pairs(1, 1); finish_pass(8'd2, 0);
        repeat (5) @(negedge clk);
        total++;
        if (done_cnt - d0 != 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_done got pulses=%0d busy=%b required 1 0", done_cnt - d0, busy);
        end
    endtask

    task automatic test_reset_mid_run;
        pl = '{5'd1, 5'd1, 5'd1, 5'd1};
        pr = '{5'd2, 5'd2, 5'd2, 5'd2};
        push_exp(8'd200); do_start(8'd200); load_pairs(0, 0);
        repeat (10) @(posedge clk);
        total++;
        if (wa_q.size() != 0 || busy !== 1'b1 || rd_seen) begin
            bad++;
            $display("FAIL run_entry got writes_left=%0d busy=%b read=%b required 0 1 0", wa_q.size(), busy, rd_seen);
        end
        #3 rst_n = 0;
        #1 check_zero("async_reset");
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1;
        ra_q.delete(); od_q.delete(); wa_q.delete(); wd_q.delete();
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            total++;
            if (bus_rd || bus_wr || busy) begin
                bad++;
                $display("FAIL post_reset_quiet got rd=%b wr=%b busy=%b required 0 0 0", bus_rd, bus_wr, busy);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_basic;
        test_run_stages;
        test_sign;
        test_stall;
        test_back_to_back;
        test_reset_mid_run;
        test_basic;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
